// File: rtl/uart_port_if.sv
// Peripheral bus bundle for the UART register window.
// The master drives requests; the slave drives ack, data and irq.
interface uart_port_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        wreq;
  logic        rreq;
  logic [7:0]  rdata;
  logic        ack;
  logic        irq;

  modport master (
    output addr, wdata, wreq, rreq,
    input  rdata, ack, irq
  );

  modport slave (
    input  addr, wdata, wreq, rreq,
    output rdata, ack, irq
  );
endinterface

// File: rtl/uart_port.sv
// 8N1 serial terminal on the 8-bit peripheral bus.
// Four registers (DATA/STAT/CTRL/DIV), TX/RX FIFOs, level irq.
module uart_port #(
  parameter logic [15:0] BASE     = 16'hfff0,
  parameter int          DEPTH    = 8,
  parameter logic [7:0]  DIV_INIT = 8'd15
) (
  input  logic       clk,
  input  logic       rst,
  uart_port_if.slave bus,
  output logic       txd,
  input  logic       rxd
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    T_IDLE, T_START, T_DATA, T_STOP
  } tx_st_t;

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_st_t;

  logic [15:0] off;
  logic        in_win;
  logic        acc;
  logic        wr;
  logic        rd;
  logic        stat_rd;

  logic        ack_q;
  logic [7:0]  rdata_q;
  logic        irq_q;
  logic [1:0]  ctrl;
  logic [7:0]  div;
  logic [7:0]  rdv;

  logic [7:0]  tx_mem [DEPTH];
  logic [AW:0] tx_wp;
  logic [AW:0] tx_rp;
  logic        tx_empty;
  logic        tx_full;
  logic        tx_push;
  logic        tx_pop;
  logic        tx_idle;
  logic [7:0]  tx_head;

  logic [7:0]  rx_mem [DEPTH];
  logic [AW:0] rx_wp;
  logic [AW:0] rx_rp;
  logic        rx_empty;
  logic        rx_full;
  logic        rx_push;
  logic        rx_pop;

  tx_st_t      tx_st;
  logic [7:0]  tx_cnt;
  logic [7:0]  tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;

  rx_st_t      rx_st;
  logic [7:0]  rx_cnt;
  logic [7:0]  rx_div;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        s1;
  logic        s2;
  logic        s3;
  logic        fall;
  logic [7:0]  half;
  logic        ovr;
  logic        ferr;

  assign off     = bus.addr - BASE;
  assign in_win  = (off[15:2] == 14'd0);
  assign acc     = !ack_q && in_win
                   && (bus.wreq || bus.rreq);
  assign wr      = acc && bus.wreq;
  assign rd      = acc && !bus.wreq;
  assign stat_rd = rd && (off[1:0] == 2'd1);

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.irq   = irq_q;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW])
                    && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW])
                    && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

  assign tx_head = tx_mem[tx_rp[AW-1:0]];
  assign tx_idle = tx_empty && (tx_st == T_IDLE);
  assign tx_pop  = !tx_empty
                   && ((tx_st == T_IDLE)
                   || (tx_st == T_STOP && tx_cnt == 8'd0));
  assign tx_push = wr && (off[1:0] == 2'd0)
                   && (!tx_full || tx_pop);

  assign rx_pop  = rd && (off[1:0] == 2'd0) && !rx_empty;
  assign rx_push = (rx_st == R_STOP) && (rx_cnt == 8'd0)
                   && s2 && (!rx_full || rx_pop);

  assign fall = s3 && !s2;
  assign half = {1'b0, div[7:1]} + {7'd0, div[0]};

  // Register read mux; an empty RX FIFO reads as zero.
  always_comb begin
    rdv = 8'h00;
    unique case (1'b1)
      off[1:0] == 2'd0:
        rdv = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];
      off[1:0] == 2'd1:
        rdv = {3'b000, tx_idle, ferr, ovr,
               tx_full, !rx_empty};
      off[1:0] == 2'd2:
        rdv = {6'd0, ctrl};
      off[1:0] == 2'd3:
        rdv = div;
    endcase
  end

  // Bus slave: single-cycle ack, control regs, irq.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      rdata_q <= 8'h00;
      irq_q   <= 1'b0;
      ctrl    <= 2'b00;
      div     <= DIV_INIT;
    end else begin
      ack_q <= acc;
      irq_q <= (ctrl[0] && !rx_empty)
               || (ctrl[1] && tx_idle);
      if (rd) rdata_q <= rdv;
      if (wr && off[1:0] == 2'd2) ctrl <= bus.wdata[1:0];
      if (wr && off[1:0] == 2'd3) div  <= bus.wdata;
    end
  end

  // FIFO storage, no reset needed on the data.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus.wdata;
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
  end

  // FIFO pointers; extra MSB separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  // Transmitter; next frame starts straight from STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st  <= T_IDLE;
      txd    <= 1'b1;
      tx_cnt <= 8'd0;
      tx_div <= 8'd0;
      tx_bit <= 3'd0;
      tx_sh  <= 8'd0;
    end else begin
      unique case (tx_st)
        T_IDLE: begin
          if (!tx_empty) begin
            tx_sh  <= tx_head;
            txd    <= 1'b0;
            tx_cnt <= div;
            tx_div <= div;
            tx_st  <= T_START;
          end
        end
        T_START: begin
          if (tx_cnt == 8'd0) begin
            txd    <= tx_sh[0];
            tx_sh  <= {1'b0, tx_sh[7:1]};
            tx_bit <= 3'd0;
            tx_cnt <= tx_div;
            tx_st  <= T_DATA;
          end else begin
            tx_cnt <= tx_cnt - 8'd1;
          end
        end
        T_DATA: begin
          if (tx_cnt == 8'd0) begin
            tx_cnt <= tx_div;
            if (tx_bit == 3'd7) begin
              txd   <= 1'b1;
              tx_st <= T_STOP;
            end else begin
              txd    <= tx_sh[0];
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx_bit <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 8'd1;
          end
        end
        T_STOP: begin
          if (tx_cnt == 8'd0) begin
            if (!tx_empty) begin
              tx_sh  <= tx_head;
              txd    <= 1'b0;
              tx_cnt <= div;
              tx_div <= div;
              tx_st  <= T_START;
            end else begin
              tx_st <= T_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 8'd1;
          end
        end
        default: tx_st <= T_IDLE;
      endcase
    end
  end

  // Two-flop synchronizer plus a delayed copy for edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Receiver; STAT read clears flags, a new error wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st  <= R_IDLE;
      rx_cnt <= 8'd0;
      rx_div <= 8'd0;
      rx_bit <= 3'd0;
      rx_sh  <= 8'd0;
      ovr    <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (stat_rd) begin
        ovr  <= 1'b0;
        ferr <= 1'b0;
      end
      unique case (rx_st)
        R_IDLE: begin
          if (fall) begin
            rx_cnt <= (half == 8'd0) ? 8'd0 : half - 8'd1;
            rx_div <= div;
            rx_st  <= R_START;
          end
        end
        R_START: begin
          if (rx_cnt == 8'd0) begin
            if (s2) begin
              rx_st <= R_IDLE;
            end else begin
              rx_bit <= 3'd0;
              rx_cnt <= rx_div;
              rx_st  <= R_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - 8'd1;
          end
        end
        R_DATA: begin
          if (rx_cnt == 8'd0) begin
            rx_sh  <= {s2, rx_sh[7:1]};
            rx_cnt <= rx_div;
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= R_STOP;
          end else begin
            rx_cnt <= rx_cnt - 8'd1;
          end
        end
        R_STOP: begin
          if (rx_cnt == 8'd0) begin
            rx_st <= R_IDLE;
            if (!s2)                    ferr <= 1'b1;
            else if (rx_full && !rx_pop) ovr <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt - 8'd1;
          end
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_port.sv
// Directed bench for uart_port: register table plus
// serial TX/RX sequences with a background TX decoder.
module tb_uart_port;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic txd;

  uart_port_if bus();

  uart_port #(
    .BASE(16'hfff0),
    .DEPTH(8),
    .DIV_INIT(8'd15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .txd(txd),
    .rxd(rxd)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] R_DATA = 2'd0;
  localparam logic [1:0] R_STAT = 2'd1;
  localparam logic [1:0] R_CTRL = 2'd2;
  localparam logic [1:0] R_DIV  = 2'd3;

  typedef struct {
    bit         w;
    logic [1:0] o;
    logic [7:0] d;
    logic [7:0] exp;
    string      nm;
  } vec_t;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         bitc   = 4;
  logic [7:0] txq[$];
  vec_t       tv[11];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic access(input bit w, input logic [1:0] o,
                        input logic [7:0] d,
                        output logic [7:0] q);
    bit ok;
    @(negedge clk);
    bus.addr  = 16'hfff0 + {14'd0, o};
    bus.wdata = d;
    bus.wreq  = w;
    bus.rreq  = !w;
    ok = 1'b0;
    q  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack) begin
        ok = 1'b1;
        q  = bus.rdata;
        break;
      end
    end
    bus.wreq = 1'b0;
    bus.rreq = 1'b0;
    check("bus_ack", ok, 1'b1);
    @(negedge clk);
  endtask

  task automatic bwr(input logic [1:0] o, input logic [7:0] d);
    logic [7:0] q;
    access(1'b1, o, d, q);
  endtask

  task automatic brd(input logic [1:0] o, output logic [7:0] q);
    access(1'b0, o, 8'h00, q);
  endtask

  task automatic send_rx(input logic [7:0] v, input bit stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (bitc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = v[i];
      repeat (bitc) @(negedge clk);
    end
    rxd = stop;
    repeat (bitc) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic no_ack(input logic [15:0] a);
    bit seen;
    @(negedge clk);
    bus.addr = a;
    bus.rreq = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.ack) seen = 1'b1;
    end
    bus.rreq = 1'b0;
    check("oow_ack", seen, 1'b0);
    check("oow_rdata_held", bus.rdata, 8'h03);
  endtask

  // Serial decoder on txd: mid-bit sampling at bitc cycles/bit.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && txd === 1'b0) begin
        int b;
        logic [7:0] v;
        b = bitc;
        v = 8'h00;
        repeat (b / 2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
          repeat (b) @(posedge clk);
          #1;
          v[i] = txd;
        end
        repeat (b) @(posedge clk);
        #1;
        check("tx_stop_bit", txd, 1'b1);
        txq.push_back(v);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q;
    logic [9:0] fr;
    int         waited;

    bus.addr  = 16'h0000;
    bus.wdata = 8'h00;
    bus.wreq  = 1'b0;
    bus.rreq  = 1'b0;

    tv[0]  = '{1'b0, R_STAT, 8'h00, 8'h10, "stat_reset"};
    tv[1]  = '{1'b0, R_DIV,  8'h00, 8'h0f, "div_reset"};
    tv[2]  = '{1'b0, R_CTRL, 8'h00, 8'h00, "ctrl_reset"};
    tv[3]  = '{1'b0, R_DATA, 8'h00, 8'h00, "data_empty"};
    tv[4]  = '{1'b1, R_CTRL, 8'hff, 8'h00, "ctrl_wr"};
    tv[5]  = '{1'b0, R_CTRL, 8'h00, 8'h03, "ctrl_mask"};
    tv[6]  = '{1'b1, R_CTRL, 8'h00, 8'h00, "ctrl_clr"};
    tv[7]  = '{1'b1, R_STAT, 8'hff, 8'h00, "stat_wr"};
    tv[8]  = '{1'b0, R_STAT, 8'h00, 8'h10, "stat_ro"};
    tv[9]  = '{1'b1, R_DIV,  8'h03, 8'h00, "div_wr"};
    tv[10] = '{1'b0, R_DIV,  8'h00, 8'h03, "div_rd"};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", txd, 1'b1);
    check("rst_ack", bus.ack, 1'b0);
    check("rst_irq", bus.irq, 1'b0);
    check("rst_rdata", bus.rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // register table
    for (int i = 0; i < 11; i++) begin
      if (tv[i].w) begin
        bwr(tv[i].o, tv[i].d);
      end else begin
        brd(tv[i].o, q);
        check(tv[i].nm, q, tv[i].exp);
      end
    end

    // out-of-window accesses
    no_ack(16'hfff4);
    no_ack(16'hffef);

    // tx_idle interrupt
    bwr(R_CTRL, 8'h02);
    repeat (2) @(posedge clk);
    #1;
    check("irq_txidle", bus.irq, 1'b1);
    bwr(R_CTRL, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("irq_off", bus.irq, 1'b0);

    // single TX frame, cycle exact, DIV=3
    bitc = 4;
    txq.delete();
    bwr(R_DATA, 8'h41);
    check("tx_before_fall", txd, 1'b1);
    fr = {1'b1, 8'h41, 1'b0};
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      check("tx_41_bit", txd, fr[(k - 1) / 4]);
    end
    repeat (5) @(posedge clk);
    #1;
    check("tx_41_count", txq.size(), 1);
    if (txq.size() > 0) check("tx_41_byte", txq[0], 8'h41);

    // TX FIFO fill at DIV=7
    bwr(R_DIV, 8'h07);
    bitc = 8;
    txq.delete();
    for (int i = 1; i <= 8; i++) bwr(R_DATA, 8'(i));
    brd(R_STAT, q);
    check("txfull_pre", q[1], 1'b0);
    bwr(R_DATA, 8'h09);
    brd(R_STAT, q);
    check("txfull_post", q[1], 1'b1);
    bwr(R_DATA, 8'h0a);
    waited = 0;
    while (txq.size() < 9 && waited < 1200) begin
      @(posedge clk);
      waited++;
    end
    check("tx_fifo_timeout", waited < 1200, 1'b1);
    repeat (120) @(posedge clk);
    #1;
    check("tx_fifo_count", txq.size(), 9);
    for (int i = 0; i < 9 && i < txq.size(); i++)
      check("tx_fifo_byte", txq[i], 8'(i + 1));
    brd(R_STAT, q);
    check("tx_drained", q, 8'h10);

    // RX frame with rx interrupt, DIV=3
    bwr(R_DIV, 8'h03);
    bitc = 4;
    bwr(R_CTRL, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    check("irq_rx_pre", bus.irq, 1'b0);
    send_rx(8'h5a, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("irq_rx", bus.irq, 1'b1);
    brd(R_STAT, q);
    check("stat_rx", q, 8'h11);
    brd(R_DATA, q);
    check("rx_5a", q, 8'h5a);
    @(posedge clk);
    #1;
    check("irq_rx_clr", bus.irq, 1'b0);
    bwr(R_CTRL, 8'h00);

    // RX overrun: 9 frames into 8 entries
    for (int i = 0; i < 9; i++) send_rx(8'h61 + 8'(i), 1'b1);
    bwr(R_DATA, 8'h77);
    brd(R_STAT, q);
    check("stat_overrun", q, 8'h05);
    brd(R_STAT, q);
    check("stat_ovr_clr", q, 8'h01);
    for (int i = 0; i < 8; i++) begin
      brd(R_DATA, q);
      check("rx_fifo_byte", q, 8'h61 + 8'(i));
    end
    brd(R_DATA, q);
    check("rx_fifo_empty", q, 8'h00);

    // framing error and glitch rejection
    repeat (60) @(posedge clk);
    send_rx(8'h33, 1'b0);
    brd(R_STAT, q);
    check("stat_framing", q, 8'h18);
    brd(R_STAT, q);
    check("stat_fe_clr", q, 8'h10);
    @(negedge clk);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    brd(R_STAT, q);
    check("stat_glitch", q, 8'h10);
    send_rx(8'ha5, 1'b1);
    brd(R_DATA, q);
    check("rx_after_glitch", q, 8'ha5);

    // reset in the middle of a TX frame
    bwr(R_DATA, 8'h00);
    repeat (10) @(posedge clk);
    #2;
    check("tx_busy_low", txd, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid_txd", txd, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    brd(R_STAT, q);
    check("stat_after_rst", q, 8'h10);
    brd(R_DIV, q);
    check("div_after_rst", q, 8'h0f);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
